// File: rtl/conv_pkg.sv
// Shared types and constants for the 1D convolution AIP: compute-core FSM states,
// default datapath sizes and the AIP configuration codes used by the interface.
package conv_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned X_LEN    = 10;
  localparam int unsigned Y_AW     = 5;
  localparam int unsigned Z_AW     = 6;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    FINISH
  } conv_state_e;

  // AIP configuration selectors decoded by the register/memory interface
  localparam logic [2:0] MEM_Y   = 3'd0;
  localparam logic [2:0] AEM_Y   = 3'd1;
  localparam logic [2:0] MEM_Z   = 3'd2;
  localparam logic [2:0] AEM_Z   = 3'd3;
  localparam logic [2:0] CONFREG = 3'd4;
  localparam logic [2:0] AONFREG = 3'd5;

endpackage

// File: rtl/conv_mac_unit.sv
// Registered multiply-accumulate: acc += x[SAMPLE_W-1:0] * y[SAMPLE_W-1:0] when valid,
// synchronous clear has priority over accumulation.
module conv_mac_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              clr,
  input  logic              valid,
  input  logic [DATA_W-1:0] x_word,
  input  logic [DATA_W-1:0] y_word,
  output logic [DATA_W-1:0] acc
);

  localparam int unsigned PROD_W = 2 * SAMPLE_W;

  logic [PROD_W-1:0] prod;
  logic              unused_hi;

  assign prod = PROD_W'(x_word[SAMPLE_W-1:0]) * PROD_W'(y_word[SAMPLE_W-1:0]);

  // Upper word bits carry no sample data
  assign unused_hi = ^{x_word[DATA_W-1:SAMPLE_W], y_word[DATA_W-1:SAMPLE_W]};

  always_ff @(posedge clk) begin
    if (rst_a) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (valid) begin
      acc <= acc + DATA_W'(prod);
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Convolution compute core: walks the tap range of each output Z[n], streams X/Y reads
// through the MAC and writes one Z word per output, then pulses done.
module conv_mac_engine #(
  parameter int unsigned DATA_W   = conv_pkg::DATA_W,
  parameter int unsigned SAMPLE_W = conv_pkg::SAMPLE_W,
  parameter int unsigned X_LEN    = conv_pkg::X_LEN,
  parameter int unsigned Y_AW     = conv_pkg::Y_AW,
  parameter int unsigned Z_AW     = conv_pkg::Z_AW
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              start,
  input  logic [4:0]        size_y,
  output logic              busy,
  output logic              done,
  output logic [Y_AW-1:0]   y_raddr,
  input  logic [DATA_W-1:0] y_rdata,
  output logic [3:0]        x_raddr,
  input  logic [DATA_W-1:0] x_rdata,
  output logic              z_we,
  output logic [Z_AW-1:0]   z_waddr,
  output logic [DATA_W-1:0] z_wdata
);

  import conv_pkg::*;

  localparam int unsigned     SZ_W   = 5;
  localparam int unsigned     XA_W   = 4;
  localparam logic [Z_AW-1:0] X_LAST = Z_AW'(X_LEN - 1);

  conv_state_e     state, state_d;
  logic [SZ_W-1:0] sz, sz_d;
  logic [Z_AW-1:0] n, n_d, n_inc;
  logic [XA_W-1:0] k, k_d, kmax, kmin_next;
  logic [Y_AW-1:0] ya, ya_d;
  logic            busy_d, done_d, z_we_d;
  logic [Z_AW-1:0] z_waddr_d;
  logic            v, acc_clr, last_n;

  // First tap of output nn: max(0, nn-(s-1))
  function automatic logic [XA_W-1:0] kmin_of(input logic [Z_AW-1:0] nn,
                                               input logic [SZ_W-1:0] s);
    kmin_of = '0;
    if (nn >= Z_AW'(s)) kmin_of = XA_W'(nn - Z_AW'(s) + Z_AW'(1));
  endfunction

  assign n_inc     = n + Z_AW'(1);
  assign kmax      = (n >= X_LAST) ? XA_W'(X_LAST) : XA_W'(n);
  assign kmin_next = kmin_of(n_inc, sz);
  assign last_n    = (n == Z_AW'(X_LEN) + Z_AW'(sz) - Z_AW'(2));

  assign x_raddr = k;
  assign y_raddr = ya;

  always_ff @(posedge clk) begin
    if (rst_a) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    sz_d      = sz;
    n_d       = n;
    k_d       = k;
    ya_d      = ya;
    busy_d    = busy;
    done_d    = 1'b0;
    z_we_d    = 1'b0;
    z_waddr_d = z_waddr;
    acc_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          sz_d = size_y;
          n_d  = '0;
          if (size_y == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            busy_d  = 1'b1;
            acc_clr = 1'b1;
            k_d     = '0;
            ya_d    = '0;
          end
        end
      end
      ISSUE: begin
        if (k == kmax) begin
          state_d = DRAIN;
        end else begin
          k_d  = k + XA_W'(1);
          ya_d = ya - Y_AW'(1);
        end
      end
      DRAIN: begin
        state_d   = WRITE;
        z_we_d    = 1'b1;
        z_waddr_d = n;
      end
      WRITE: begin
        if (last_n) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = ISSUE;
          n_d     = n_inc;
          k_d     = kmin_next;
          ya_d    = Y_AW'(n_inc - Z_AW'(kmin_next));
          acc_clr = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // v tracks read data returning one cycle after each issued address
  always_ff @(posedge clk) begin
    if (rst_a) begin
      sz      <= '0;
      n       <= '0;
      k       <= '0;
      ya      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      z_we    <= 1'b0;
      z_waddr <= '0;
      v       <= 1'b0;
    end else begin
      sz      <= sz_d;
      n       <= n_d;
      k       <= k_d;
      ya      <= ya_d;
      busy    <= busy_d;
      done    <= done_d;
      z_we    <= z_we_d;
      z_waddr <= z_waddr_d;
      v       <= (state == ISSUE);
    end
  end

  conv_mac_unit #(
    .DATA_W  (DATA_W),
    .SAMPLE_W(SAMPLE_W)
  ) u_mac (
    .clk   (clk),
    .rst_a (rst_a),
    .clr   (acc_clr),
    .valid (v),
    .x_word(x_rdata),
    .y_word(y_rdata),
    .acc   (z_wdata)
  );

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: behavioural X/Y RAMs with 1-cycle read latency
// and a negedge monitor capturing Z writes, done pulses and busy activity.
module tb_conv_mac_engine;

  logic        clk    = 1'b0;
  logic        rst_a  = 1'b1;
  logic        start  = 1'b0;
  logic [4:0]  size_y = 5'd0;
  logic        busy, done, z_we;
  logic [4:0]  y_raddr;
  logic [3:0]  x_raddr;
  logic [5:0]  z_waddr;
  logic [31:0] y_rdata, x_rdata, z_wdata;

  logic [31:0] y_mem [32];
  logic [31:0] x_mem [16];
  logic [31:0] zcap  [64];
  int          wcyc  [64];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int wr_cnt      = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int start_cyc   = 0;
  int clr_gen     = 0;
  int seen_gen    = -1;
  bit busy_seen   = 1'b0;

  int unsigned exp_basic [14] = '{0, 1, 4, 10, 20, 30, 40, 50, 60, 70, 80, 79, 66, 40};

  conv_mac_engine dut (
    .clk    (clk),
    .rst_a  (rst_a),
    .start  (start),
    .size_y (size_y),
    .busy   (busy),
    .done   (done),
    .y_raddr(y_raddr),
    .y_rdata(y_rdata),
    .x_raddr(x_raddr),
    .x_rdata(x_rdata),
    .z_we   (z_we),
    .z_waddr(z_waddr),
    .z_wdata(z_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    y_rdata <= y_mem[y_raddr];
    x_rdata <= x_mem[x_raddr];
    cyc     <= cyc + 1;
  end

  always @(negedge clk) begin
    if (clr_gen != seen_gen) begin
      seen_gen  = clr_gen;
      wr_cnt    = 0;
      done_cnt  = 0;
      busy_seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
        zcap[i] = 32'hDEAD_BEEF;
        wcyc[i] = 0;
      end
    end
    if (z_we) begin
      zcap[z_waddr] = z_wdata;
      wcyc[z_waddr] = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic clear_capture();
    clr_gen++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called just after a negedge; size_y is scrambled afterwards to prove it is latched
  task automatic pulse_start(input logic [4:0] s);
    start     = 1'b1;
    size_y    = s;
    start_cyc = cyc;
    @(negedge clk);
    start  = 1'b0;
    size_y = 5'd31;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    vectors++;
    if (done_cnt == 0) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles, required one pulse", budget);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) x_mem[i] = (i < 10) ? 32'(i + 1) : 32'h0000_0077;
    for (int i = 0; i < 32; i++) y_mem[i] = (i < 5) ? 32'(i) : 32'h0000_0055;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, z_we} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/done/z_we got %b expected 000", {busy, done, z_we});
    end
    vectors++;
    if ({y_raddr, x_raddr, z_waddr, z_wdata} !== 47'd0) begin
      miscompares++;
      $display("FAIL reset_bus: y_raddr=%0d x_raddr=%0d z_waddr=%0d z_wdata=%0d expected all 0",
               y_raddr, x_raddr, z_waddr, z_wdata);
    end
    // start during the last reset cycle must be dropped
    start  = 1'b1;
    size_y = 5'd5;
    @(negedge clk);
    rst_a = 1'b0;
    start = 1'b0;
    clear_capture();
    repeat (20) @(negedge clk);
    @(posedge clk);
    vectors++;
    if (wr_cnt != 0) begin
      miscompares++;
      $display("FAIL idle_writes: got %0d z_we expected 0", wr_cnt);
    end
    vectors++;
    if (done_cnt != 0 || busy_seen) begin
      miscompares++;
      $display("FAIL idle_activity: done pulses %0d busy_seen %0d expected 0 0", done_cnt, busy_seen);
    end
  endtask

  task automatic test_basic();
    load_basic();
    clear_capture();
    pulse_start(5'd5);
    wait_done(300);
    vectors++;
    if (wr_cnt != 14) begin
      miscompares++;
      $display("FAIL basic_writes: got %0d expected 14", wr_cnt);
    end
    for (int i = 0; i < 14; i++) begin
      vectors++;
      if (zcap[i] !== exp_basic[i]) begin
        miscompares++;
        $display("FAIL basic_z[%0d]: got %0d expected %0d", i, zcap[i], exp_basic[i]);
      end
    end
    vectors++;
    if (zcap[14] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL basic_z_overrun: z[14] got %h expected untouched", zcap[14]);
    end
    // taps 1,2,3,4,5x6,4,3,2,1 = 50, plus 2 per output over 14 outputs, plus FINISH
    vectors++;
    if (done_cyc - start_cyc != 79) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles expected 79", done_cyc - start_cyc);
    end
    vectors++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: pulses %0d busy %b expected 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 16; i++) x_mem[i] = (i < 10) ? 32'(i + 1) : 32'h0000_0077;
    for (int i = 0; i < 32; i++) y_mem[i] = (i == 0) ? 32'd3 : 32'h0000_0055;
    clear_capture();
    pulse_start(5'd1);
    wait_done(300);
    vectors++;
    if (wr_cnt != 10) begin
      miscompares++;
      $display("FAIL single_writes: got %0d expected 10", wr_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (zcap[i] !== 32'(3 * (i + 1))) begin
        miscompares++;
        $display("FAIL single_z[%0d]: got %0d expected %0d", i, zcap[i], 3 * (i + 1));
      end
    end
    vectors++;
    if (wcyc[0] - start_cyc != 3) begin
      miscompares++;
      $display("FAIL single_first_write: got %0d cycles expected 3", wcyc[0] - start_cyc);
    end
    for (int i = 1; i < 10; i++) begin
      vectors++;
      if (wcyc[i] - wcyc[i-1] != 3) begin
        miscompares++;
        $display("FAIL single_spacing[%0d]: got %0d cycles expected 3", i, wcyc[i] - wcyc[i-1]);
      end
    end
    // Counting the start cycle as cycle 1, done lands on cycle 32
    vectors++;
    if (done_cyc - start_cyc != 31) begin
      miscompares++;
      $display("FAIL single_latency: got %0d cycles after start expected 31", done_cyc - start_cyc);
    end
  endtask

  task automatic test_empty();
    clear_capture();
    pulse_start(5'd0);
    wait_done(20);
    vectors++;
    if (done_cyc - start_cyc != 1) begin
      miscompares++;
      $display("FAIL empty_latency: got %0d cycles expected 1", done_cyc - start_cyc);
    end
    vectors++;
    if (wr_cnt != 0 || busy_seen || done_cnt != 1) begin
      miscompares++;
      $display("FAIL empty_activity: writes %0d busy_seen %0d pulses %0d expected 0 0 1",
               wr_cnt, busy_seen, done_cnt);
    end
  endtask

  task automatic test_masking();
    for (int i = 0; i < 16; i++) x_mem[i] = (i < 10) ? 32'hFFFF_FF01 : 32'h0000_0077;
    for (int i = 0; i < 32; i++) y_mem[i] = (i == 0) ? 32'hABCD_0002 : 32'h0000_0055;
    clear_capture();
    pulse_start(5'd1);
    repeat (8) @(negedge clk);
    start  = 1'b1;
    size_y = 5'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(300);
    vectors++;
    if (wr_cnt != 10 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL mask_counts: writes %0d pulses %0d expected 10 1", wr_cnt, done_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (zcap[i] !== 32'd2) begin
        miscompares++;
        $display("FAIL mask_z[%0d]: got %h expected 2", i, zcap[i]);
      end
    end
    vectors++;
    if (done_cyc - start_cyc != 31) begin
      miscompares++;
      $display("FAIL mask_latency: got %0d cycles expected 31", done_cyc - start_cyc);
    end
  endtask

  task automatic test_reset_mid_run();
    int i;
    load_basic();
    clear_capture();
    pulse_start(5'd5);
    for (i = 0; i < 300 && wr_cnt < 5; i++) @(posedge clk);
    vectors++;
    if (wr_cnt != 5) begin
      miscompares++;
      $display("FAIL abort_reach: got %0d writes expected 5 before reset", wr_cnt);
    end
    #1 rst_a = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, z_we} !== 3'b000 || z_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_reset_out: busy/done/z_we %b z_wdata %0d expected 000 0",
               {busy, done, z_we}, z_wdata);
    end
    rst_a = 1'b0;
    repeat (150) @(negedge clk);
    @(posedge clk);
    vectors++;
    if (wr_cnt != 5 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: writes %0d pulses %0d expected 5 0", wr_cnt, done_cnt);
    end
    @(negedge clk);
    clear_capture();
    pulse_start(5'd5);
    wait_done(300);
    vectors++;
    if (wr_cnt != 14 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL rerun_counts: writes %0d pulses %0d expected 14 1", wr_cnt, done_cnt);
    end
    for (int j = 0; j < 14; j++) begin
      vectors++;
      if (zcap[j] !== exp_basic[j]) begin
        miscompares++;
        $display("FAIL rerun_z[%0d]: got %0d expected %0d", j, zcap[j], exp_basic[j]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) x_mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) y_mem[i] = 32'd0;
    test_reset();
    test_basic();
    test_single();
    test_empty();
    test_masking();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
